pll_loop_filter: RTL and testbench

//  Digital PI loop filter for the theremin sensor PLL; sits directly downstream of phase_shift_ddr.

---
 rtl/pll_loop_filter_pkg.sv | 45 ++++
 rtl/pll_loop_filter_lock.sv | 44 ++++
 rtl/pll_loop_filter.sv | 112 +++++++++++
 tb/tb_pll_loop_filter.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_loop_filter_pkg.sv
// Shared types and saturation helpers for the PLL PI loop filter.
// All arithmetic helpers operate on a 64-bit signed carrier; callers pick the target width.
package pll_loop_filter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        SUM  = 2'd2,
        OUT  = 2'd3
    } state_t;

    localparam int WIDE_BITS = 64;
    typedef logic signed [WIDE_BITS-1:0] wide_t;

    // Clamp a signed value into the range of a signed 'width'-bit number.
    function automatic wide_t sat_signed(input wide_t value, input int width);
        wide_t max_v;
        wide_t min_v;
        wide_t res;
        max_v = (wide_t'(1) <<< (width - 1)) - wide_t'(1);
        min_v = -(wide_t'(1) <<< (width - 1));
        res   = value;
        if (value > max_v) begin
            res = max_v;
        end else if (value < min_v) begin
            res = min_v;
        end
        return res;
    endfunction

    // Clamp a signed value into [0, 2^width-1].
    function automatic wide_t clamp_unsigned(input wide_t value, input int width);
        wide_t max_v;
        wide_t res;
        max_v = (wide_t'(1) <<< width) - wide_t'(1);
        res   = value;
        if (value < wide_t'(0)) begin
            res = wide_t'(0);
        end else if (value > max_v) begin
            res = max_v;
        end
        return res;
    endfunction

endpackage

// File: rtl/pll_loop_filter_lock.sv
// Lock detector: counts consecutive small-error updates and saturates at LOCK_COUNT.
// Only instantiated when PLL_LOOP_FILTER_LOCK_DETECT_EN is defined.
module pll_lock_detect #(
    parameter int POSITION_BITS  = 14,
    parameter int LOCK_THRESHOLD = 16,
    parameter int LOCK_COUNT     = 64
) (
    input  logic                            CLK,
    input  logic                            RESET,
    input  logic signed [POSITION_BITS-1:0] i_err,
    input  logic                            i_strobe,
    output logic                            o_locked
);
    localparam int CW = $clog2(LOCK_COUNT + 1);
    localparam logic [CW-1:0]          CNT_MAX = CW'(LOCK_COUNT);
    localparam logic [POSITION_BITS:0] THR     = (POSITION_BITS + 1)'(LOCK_THRESHOLD);

    logic [CW-1:0]                r_count;
    logic signed [POSITION_BITS:0] w_err_ext;
    logic [POSITION_BITS:0]       w_abs;
    logic                         w_in_lock;

    // One extra bit keeps |most-negative| representable, so it compares as large.
    always_comb begin
        w_err_ext = {i_err[POSITION_BITS-1], i_err};
        w_abs     = w_err_ext[POSITION_BITS] ? -w_err_ext : w_err_ext;
        w_in_lock = (w_abs <= THR);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_count <= '0;
        end else if (i_strobe) begin
            if (!w_in_lock) begin
                r_count <= '0;
            end else if (r_count != CNT_MAX) begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    assign o_locked = (r_count == CNT_MAX);

endmodule

// File: rtl/pll_loop_filter.sv
// Digital PI loop filter: phase error -> saturating integrator -> clamped NCO frequency word.
// Optional lock detector enabled with the PLL_LOOP_FILTER_LOCK_DETECT_EN macro.
module pll_loop_filter
    import pll_loop_filter_pkg::*;
#(
    parameter int                   POSITION_BITS  = 14,
    parameter int                   FREQ_BITS      = 32,
    parameter int                   KP_SHIFT       = 8,
    parameter int                   KI_SHIFT       = 2,
    parameter logic [FREQ_BITS-1:0] FREQ_INIT      = 32'h1000_0000,
    parameter int                   LOCK_THRESHOLD = 16,
    parameter int                   LOCK_COUNT     = 64
) (
    input  logic                            CLK,
    input  logic                            RESET,
    input  logic                            CE,
    input  logic signed [POSITION_BITS-1:0] PHASE_DIFFERENCE,
    input  logic                            PHASE_VALID,
    output logic [FREQ_BITS-1:0]            FREQ_WORD,
    output logic                            FREQ_VALID,
    output logic                            SATURATED,
    output logic                            OVERRUN
`ifdef PLL_LOOP_FILTER_LOCK_DETECT_EN
    ,
    output logic                            LOCKED
`endif
);
    localparam int IW = FREQ_BITS + 1;

    state_t                          r_state;
    state_t                          w_state_next;
    logic signed [POSITION_BITS-1:0] r_err;
    logic signed [IW-1:0]            r_integ;
    logic                            r_acc_sat;
    wide_t                           w_acc_sum;
    wide_t                           w_acc_sat;
    wide_t                           w_s;
    wide_t                           w_out;
    logic                            w_out_strobe;

    // SUM uses the integrator value already updated in ACC.
    always_comb begin
        w_acc_sum = wide_t'(r_integ) + (wide_t'(r_err) <<< KI_SHIFT);
        w_acc_sat = sat_signed(w_acc_sum, IW);
        w_s       = wide_t'(FREQ_INIT) + wide_t'(r_integ) + (wide_t'(r_err) <<< KP_SHIFT);
        w_out     = clamp_unsigned(w_s, FREQ_BITS);
    end

    always_comb begin
        w_state_next = r_state;
        if (CE) begin
            unique case (r_state)
                IDLE:    if (PHASE_VALID) w_state_next = ACC;
                ACC:     w_state_next = SUM;
                SUM:     w_state_next = OUT;
                OUT:     w_state_next = IDLE;
                default: w_state_next = IDLE;
            endcase
        end
    end

    // The output register loads on the SUM->OUT edge so FREQ_VALID and FREQ_WORD appear together.
    assign w_out_strobe = CE && (r_state == SUM);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state    <= IDLE;
            r_err      <= '0;
            r_integ    <= '0;
            r_acc_sat  <= 1'b0;
            FREQ_WORD  <= FREQ_INIT;
            FREQ_VALID <= 1'b0;
            SATURATED  <= 1'b0;
            OVERRUN    <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            FREQ_VALID <= w_out_strobe;
            if (CE) begin
                if (PHASE_VALID && (r_state != IDLE)) begin
                    OVERRUN <= 1'b1;
                end
                case (r_state)
                    IDLE: if (PHASE_VALID) r_err <= PHASE_DIFFERENCE;
                    ACC: begin
                        r_integ   <= w_acc_sat[IW-1:0];
                        r_acc_sat <= (w_acc_sat != w_acc_sum);
                    end
                    SUM: begin
                        FREQ_WORD <= w_out[FREQ_BITS-1:0];
                        SATURATED <= r_acc_sat | (w_out != w_s);
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef PLL_LOOP_FILTER_LOCK_DETECT_EN
    pll_lock_detect #(
        .POSITION_BITS (POSITION_BITS),
        .LOCK_THRESHOLD(LOCK_THRESHOLD),
        .LOCK_COUNT    (LOCK_COUNT)
    ) u_lock (
        .CLK     (CLK),
        .RESET   (RESET),
        .i_err   (r_err),
        .i_strobe(w_out_strobe),
        .o_locked(LOCKED)
    );
`endif

endmodule

// File: tb/tb_pll_loop_filter.sv
// Self-checking bench: two filters (default centre and centre=0) driven in lockstep against
// an arithmetic reference model of the PI update, output clamp, overrun flag and lock count.
module tb_pll_loop_filter;

    logic               CLK = 1'b0;
    logic               RESET = 1'b0;
    logic               CE = 1'b1;
    logic               PHASE_VALID = 1'b0;
    logic signed [13:0] PHASE_DIFFERENCE = '0;
    logic [31:0]        fw_a, fw_b;
    logic               fv_a, fv_b, sat_a, sat_b, ovr_a, ovr_b;
`ifdef PLL_LOOP_FILTER_LOCK_DETECT_EN
    logic               lk_a, lk_b;
`endif

    always #5 CLK = ~CLK;

    pll_loop_filter dut_a (
        .CLK(CLK), .RESET(RESET), .CE(CE),
        .PHASE_DIFFERENCE(PHASE_DIFFERENCE), .PHASE_VALID(PHASE_VALID),
        .FREQ_WORD(fw_a), .FREQ_VALID(fv_a), .SATURATED(sat_a), .OVERRUN(ovr_a)
`ifdef PLL_LOOP_FILTER_LOCK_DETECT_EN
        , .LOCKED(lk_a)
`endif
    );

    pll_loop_filter #(.FREQ_INIT(32'h0000_0000)) dut_b (
        .CLK(CLK), .RESET(RESET), .CE(CE),
        .PHASE_DIFFERENCE(PHASE_DIFFERENCE), .PHASE_VALID(PHASE_VALID),
        .FREQ_WORD(fw_b), .FREQ_VALID(fv_b), .SATURATED(sat_b), .OVERRUN(ovr_b)
`ifdef PLL_LOOP_FILTER_LOCK_DETECT_EN
        , .LOCKED(lk_b)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;

    localparam longint IMAX = (longint'(1) << 32) - 1;
    localparam longint IMIN = -(longint'(1) << 32);
    localparam longint WMAX = (longint'(1) << 32) - 1;

    longint m_init [2] = '{longint'(32'h1000_0000), longint'(0)};
    longint m_integ[2];
    longint m_word [2];
    bit     m_sat  [2];
    bit     m_ovr;
    int     m_lock_cnt;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        for (int d = 0; d < 2; d++) begin
            m_integ[d] = 0;
            m_word[d]  = m_init[d];
            m_sat[d]   = 1'b0;
        end
        m_ovr      = 1'b0;
        m_lock_cnt = 0;
    endfunction

    // Integrator gain 4, proportional gain 256, output held to [0, 2^32-1].
    function automatic void model_step(input int err);
        for (int d = 0; d < 2; d++) begin
            longint acc;
            longint s;
            bit     ca;
            bit     co;
            ca  = 1'b0;
            co  = 1'b0;
            acc = m_integ[d] + longint'(err) * 4;
            if (acc > IMAX) begin acc = IMAX; ca = 1'b1; end
            if (acc < IMIN) begin acc = IMIN; ca = 1'b1; end
            m_integ[d] = acc;
            s = m_init[d] + acc + longint'(err) * 256;
            if (s < 0)    begin s = 0;    co = 1'b1; end
            if (s > WMAX) begin s = WMAX; co = 1'b1; end
            m_word[d] = s;
            m_sat[d]  = ca | co;
        end
        if (err <= 16 && err >= -16) begin
            if (m_lock_cnt < 64) m_lock_cnt++;
        end else begin
            m_lock_cnt = 0;
        end
    endfunction

    task automatic do_reset();
        @(negedge CLK);
        RESET = 1'b1;
        PHASE_VALID = 1'b0;
        CE = 1'b1;
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
        model_reset();
        check("rst_word_a", fw_a, 32'h1000_0000);
        check("rst_word_b", fw_b, 32'h0000_0000);
        check("rst_fv", fv_a, 1'b0);
        check("rst_sat", sat_a, 1'b0);
        check("rst_ovr_a", ovr_a, 1'b0);
        check("rst_ovr_b", ovr_b, 1'b0);
`ifdef PLL_LOOP_FILTER_LOCK_DETECT_EN
        check("rst_lock", lk_a, 1'b0);
`endif
        $display("reset  word_a=%h word_b=%h", fw_a, fw_b);
    endtask

    // One sample; optional CE-low gap while in ACC; optional PHASE_VALID poke during OUT.
    task automatic send(input int err, input int gap, input bit poke_out);
        int n;
        @(negedge CLK);
        PHASE_DIFFERENCE = 14'(err);
        PHASE_VALID = 1'b1;
        @(negedge CLK);
        PHASE_VALID = 1'b0;
        n = 1;
        if (gap > 0) CE = 1'b0;
        while (!fv_a && n < 12 + gap) begin
            @(negedge CLK);
            n++;
            if (n == 1 + gap) CE = 1'b1;
        end
        CE = 1'b1;
        model_step(err);
        check("latency", n, 3 + gap);
        check("fv_b", fv_b, 1'b1);
        check("word_a", fw_a, m_word[0]);
        check("word_b", fw_b, m_word[1]);
        check("sat_a", sat_a, m_sat[0]);
        check("sat_b", sat_b, m_sat[1]);
        check("ovr_a", ovr_a, m_ovr);
        check("ovr_b", ovr_b, m_ovr);
`ifdef PLL_LOOP_FILTER_LOCK_DETECT_EN
        check("lock_a", lk_a, m_lock_cnt == 64);
        check("lock_b", lk_b, m_lock_cnt == 64);
`endif
        $display("sample err=%0d gap=%0d lat=%0d word_a=%h word_b=%h sat=%b/%b",
                 err, gap, n, fw_a, fw_b, sat_a, sat_b);
        if (poke_out) begin
            PHASE_DIFFERENCE = 14'(100);
            PHASE_VALID = 1'b1;
            m_ovr = 1'b1;
        end
        @(negedge CLK);
        PHASE_VALID = 1'b0;
        check("fv_pulse", fv_a, 1'b0);
    endtask

    task automatic quiet(input int cycles, input string tag);
        int p;
        p = 0;
        repeat (cycles) begin
            @(negedge CLK);
            if (fv_a || fv_b) p++;
        end
        check(tag, p, 0);
    endtask

    initial begin
        int pulses;
        int err;
        int gap;

        do_reset();

        send(32, 0, 1'b0);
        check("vec_p32", fw_a, 32'h1000_2080);
        send(0, 0, 1'b0);
        check("vec_zero", fw_a, 32'h1000_0080);
        send(-32, 0, 1'b0);
        check("vec_m32", fw_a, 32'h0FFF_E000);

        do_reset();
        send(-1, 0, 1'b0);
        check("clamp_lo_word", fw_b, 32'h0000_0000);
        check("clamp_lo_sat", sat_b, 1'b1);
        send(1, 0, 1'b0);
        check("recover_word", fw_b, 32'h0000_0100);
        check("recover_sat", sat_b, 1'b0);

        send(20, 5, 1'b0);

        // Back-to-back strobes: only the first is taken.
        @(negedge CLK);
        PHASE_DIFFERENCE = 14'(5);
        PHASE_VALID = 1'b1;
        @(negedge CLK);
        PHASE_DIFFERENCE = 14'(7);
        @(negedge CLK);
        PHASE_VALID = 1'b0;
        pulses = 0;
        repeat (8) begin
            @(negedge CLK);
            if (fv_a) begin
                pulses++;
                if (pulses == 1) begin
                    model_step(5);
                    check("ovr_word_a", fw_a, m_word[0]);
                    check("ovr_word_b", fw_b, m_word[1]);
                end
            end
        end
        m_ovr = 1'b1;
        check("ovr_pulses", pulses, 1);
        check("ovr_flag", ovr_a, 1'b1);
        $display("overrun pulses=%0d word_a=%h ovr=%b", pulses, fw_a, ovr_a);

        send(3, 0, 1'b1);
        quiet(6, "drop_at_out");
        check("ovr_sticky", ovr_b, 1'b1);

        do_reset();

        // Reset while a sample is in ACC must discard it.
        @(negedge CLK);
        PHASE_DIFFERENCE = 14'(50);
        PHASE_VALID = 1'b1;
        @(negedge CLK);
        PHASE_VALID = 1'b0;
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        model_reset();
        quiet(6, "midreset_no_fv");
        check("midreset_word", fw_a, m_word[0]);
        $display("midreset word_a=%h", fw_a);
        send(4, 0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 1) == 0) err = int'($urandom_range(0, 80)) - 40;
            else                           err = int'($urandom_range(0, 16383)) - 8192;
            gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
            send(err, gap, 1'b0);
        end

`ifdef PLL_LOOP_FILTER_LOCK_DETECT_EN
        do_reset();
        for (int i = 1; i <= 64; i++) begin
            send(10, 0, 1'b0);
            if (i == 63) check("lock_63", lk_a, 1'b0);
            if (i == 64) check("lock_64", lk_a, 1'b1);
        end
        send(-17, 0, 1'b0);
        check("lock_drop", lk_a, 1'b0);
        for (int i = 0; i < 3; i++) send(16, 0, 1'b0);
        send(-8192, 0, 1'b0);
        check("lock_mostneg", lk_a, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_errors, n_checks);
        $fatal(1);
    end

endmodule
